// File: rtl/mskand_rnd_source_pkg.sv
// Shared constants, state encoding and sizing helper for the HPC2 randomness source.
// Holds the lane width, the zero-seed substitute and the xorshift64 shift amounts.
package mskand_rnd_source_pkg;

    localparam int          LANE_W   = 64;
    localparam logic [63:0] ZERO_SUB = 64'h9E3779B97F4A7C15;

    localparam int SH_A = 13;
    localparam int SH_B = 7;
    localparam int SH_C = 17;

    typedef enum logic [1:0] {
        ST_SEED = 2'd0,
        ST_WARM = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Bits of fresh randomness per cycle for n_and gadgets with d shares.
    function automatic int and_pini_nrnd(input int d, input int n_and);
        return n_and * d * (d - 1) / 2;
    endfunction

endpackage

// File: rtl/mskand_rnd_lane.sv
// Single 64-bit xorshift64 lane register with load, step and hold controls.
// A load takes priority over a step. With neither control high, the lane holds.
module mskand_rnd_lane
    import mskand_rnd_source_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [63:0] load_val,
    output logic [63:0] q
);

    logic [63:0] s1, s2, s3;

    always_comb begin
        s1 = q ^ (q << SH_A);
        s2 = s1 ^ (s1 >> SH_B);
        s3 = s2 ^ (s2 << SH_C);
    end

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (load)
            q <= load_val;
        else if (step)
            q <= s3;
    end

endmodule

// File: rtl/mskand_rnd_source.sv
// Fresh-randomness source for a bank of masked HPC2 AND gadgets.
// Uses parallel xorshift64 lanes, seeded over valid/ready, with a warm-up phase before rnd_valid.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_SEED | accepting seed words, one per lane, in order 0..L-1
// ST_WARM | lanes free-running for WARMUP steps, output not yet valid
// ST_RUN  | rnd_valid high; lanes step whenever en is high
module mskand_rnd_source
    import mskand_rnd_source_pkg::*;
#(
    parameter int d      = 2,
    parameter int N_AND  = 34,
    parameter int WARMUP = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [63:0]                           seed_data,
    input  logic                                  seed_valid,
    output logic                                  seed_ready,
    input  logic                                  reseed,
    input  logic                                  en,
    output logic [and_pini_nrnd(d, N_AND)-1:0]    rnd,
    output logic                                  rnd_valid
);

    localparam int NRND = and_pini_nrnd(d, N_AND);
    localparam int L    = (NRND + LANE_W - 1) / LANE_W;
    localparam int CW   = (L > 1) ? $clog2(L) : 1;
    localparam int WW   = $clog2(WARMUP + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(L - 1);
    localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP - 1);

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [WW-1:0]       warm_cnt;
    logic [L*LANE_W-1:0] lanes_flat;
    logic                xfer;
    logic                step_all;
    logic [63:0]         seed_word;

    // reseed outranks both a seed transfer and a lane step
    assign xfer      = (state == ST_SEED) && seed_valid && !reseed;
    assign step_all  = !reseed && ((state == ST_WARM) || ((state == ST_RUN) && en));
    assign seed_word = (seed_data == 64'd0) ? ZERO_SUB : seed_data;

    for (genvar i = 0; i < L; i++) begin : g_lane
        mskand_rnd_lane u_lane (
            .clk      (clk),
            .rst      (rst),
            .load     (xfer && (cnt == CW'(i))),
            .step     (step_all),
            .load_val (seed_word),
            .q        (lanes_flat[i*LANE_W +: LANE_W])
        );
    end

    assign rnd = lanes_flat[NRND-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_SEED;
            cnt        <= '0;
            warm_cnt   <= '0;
            rnd_valid  <= 1'b0;
            seed_ready <= 1'b1;
        end else begin
            case (state)
                ST_SEED: begin
                    if (reseed) begin
                        cnt <= '0;
                    end else if (seed_valid) begin
                        if (cnt == CNT_LAST) begin
                            state      <= ST_WARM;
                            cnt        <= '0;
                            warm_cnt   <= '0;
                            seed_ready <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_WARM: begin
                    if (reseed) begin
                        state      <= ST_SEED;
                        cnt        <= '0;
                        seed_ready <= 1'b1;
                    end else if (warm_cnt == WARM_LAST) begin
                        state     <= ST_RUN;
                        rnd_valid <= 1'b1;
                    end else begin
                        warm_cnt <= warm_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (reseed) begin
                        state      <= ST_SEED;
                        cnt        <= '0;
                        rnd_valid  <= 1'b0;
                        seed_ready <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_SEED;
                    cnt        <= '0;
                    warm_cnt   <= '0;
                    rnd_valid  <= 1'b0;
                    seed_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
